mem_access_unit: RTL and testbench

- Memory-stage access unit between the EX/MEM register and the MEM/WB register.
- Generates byte enables, aligned write data, and byte/halfword read lanes for the internal data memory.
- Detects misaligned accesses.
- Runs a req/ack handshake FSM toward the peripheral bridge, stalling the pipeline until device read data (CPURD) is captured for MEM/WB.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/lane_ctrl.sv | 48 ++++
 rtl/mem_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access unit.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2,
        MEM_RSVD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mau_state_e;

    localparam logic [31:0] DEV_BASE_DEFAULT = 32'h0000_7F00;

    // Device transaction payload latched at request time.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } dev_req_t;

endpackage

// File: rtl/lane_ctrl.sv
// Combinational lane logic: misalignment, byte enables, write replication
// and read lane selection for byte/half/word accesses.
module lane_ctrl
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic        misaligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [15:0] rdata_h_o,
    output logic [7:0]  rdata_b_o
);

    always_comb begin
        misaligned_o = 1'b0;
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        case (mem_size_e'(size_i))
            MEM_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_HALF: begin
                misaligned_o = addr_lo_i[0];
                be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
            end
            // Reserved size code behaves as a word access.
            default: begin
                misaligned_o = |addr_lo_i;
            end
        endcase
    end

    always_comb begin
        rdata_h_o = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (addr_lo_i)
            2'd0:    rdata_b_o = rdata_i[7:0];
            2'd1:    rdata_b_o = rdata_i[15:8];
            2'd2:    rdata_b_o = rdata_i[23:16];
            default: rdata_b_o = rdata_i[31:24];
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: internal data memory lanes plus a req/ack device
// bus FSM that stalls the pipeline. Define MEM_ACCESS_STATS_EN for counters.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter logic [31:0] DEV_BASE = DEV_BASE_DEFAULT,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    input  logic        InterruptRequest,
    input  logic [31:0] DMRData,
    output logic        DMWE,
    output logic [3:0]  DMBE,
    output logic [31:0] DMWData,
    output logic        DevReq,
    output logic        DevWE,
    output logic [31:0] DevAddr,
    output logic [3:0]  DevBE,
    output logic [31:0] DevWData,
    input  logic        DevAck,
    input  logic [31:0] DevRData,
    output logic [31:0] CPURD,
    output logic [15:0] ReadDataHM,
    output logic [7:0]  ReadDataBM,
    output logic        StallM,
    output logic        AdELM,
    output logic        AdESM,
`ifdef MEM_ACCESS_STATS_EN
    output logic [31:0] DevAccessCount,
    output logic [31:0] StallCycleCount,
`endif
    output logic        BusErrM
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    logic        misaligned;
    logic        aligned;
    logic        is_dev;
    logic        devacc;
    logic [3:0]  be;
    logic [31:0] wdata_rep;

    mau_state_e       state_q, state_d;
    logic             req_q, req_d;
    dev_req_t         pay_q, pay_d;
    logic [31:0]      cpurd_q, cpurd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             stall_c;
    logic             start_c;

    lane_ctrl u_lane_ctrl (
        .size_i       (MemSizeM),
        .addr_lo_i    (AddrM[1:0]),
        .wdata_i      (WriteDataM),
        .rdata_i      (DMRData),
        .misaligned_o (misaligned),
        .be_o         (be),
        .wdata_o      (wdata_rep),
        .rdata_h_o    (ReadDataHM),
        .rdata_b_o    (ReadDataBM)
    );

    assign aligned = ~misaligned;
    assign is_dev  = (AddrM >= DEV_BASE);
    assign devacc  = (MemReadM | MemWriteM) & aligned & is_dev;

    assign AdELM   = MemReadM & misaligned;
    assign AdESM   = MemWriteM & misaligned;
    assign DMWE    = MemWriteM & aligned & ~is_dev & ~InterruptRequest;
    assign DMBE    = be;
    assign DMWData = wdata_rep;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            pay_q   <= '0;
            cpurd_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pay_q   <= pay_d;
            cpurd_q <= cpurd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        pay_d   = pay_q;
        cpurd_d = cpurd_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stall_c = 1'b0;
        start_c = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (devacc && !InterruptRequest) begin
                    start_c = 1'b1;
                    stall_c = 1'b1;
                    req_d   = 1'b1;
                    pay_d   = '{we: MemWriteM, addr: AddrM, be: be, wdata: wdata_rep};
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Interrupts are not honoured here: the bus transaction must finish.
                stall_c = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (DevAck) begin
                    if (!pay_q.we) begin
                        cpurd_d = DevRData;
                    end
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    cpurd_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign StallM   = stall_c;
    assign BusErrM  = (state_q == DONE) & err_q;
    assign DevReq   = req_q;
    assign DevWE    = pay_q.we;
    assign DevAddr  = pay_q.addr;
    assign DevBE    = pay_q.be;
    assign DevWData = pay_q.wdata;
    assign CPURD    = cpurd_q;

`ifdef MEM_ACCESS_STATS_EN
    logic [31:0] dev_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dev_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (start_c) begin
                dev_cnt_q <= dev_cnt_q + 32'd1;
            end
            if (stall_c) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign DevAccessCount  = dev_cnt_q;
    assign StallCycleCount = stall_cnt_q;
`else
    logic unused_start;
    assign unused_start = start_c;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [1:0]  MemSizeM;
    logic [31:0] AddrM, WriteDataM;
    logic        InterruptRequest;
    logic [31:0] DMRData;
    logic        DMWE;
    logic [3:0]  DMBE;
    logic [31:0] DMWData;
    logic        DevReq, DevWE;
    logic [31:0] DevAddr;
    logic [3:0]  DevBE;
    logic [31:0] DevWData;
    logic        DevAck;
    logic [31:0] DevRData;
    logic [31:0] CPURD;
    logic [15:0] ReadDataHM;
    logic [7:0]  ReadDataBM;
    logic        StallM, AdELM, AdESM, BusErrM;
`ifdef MEM_ACCESS_STATS_EN
    logic [31:0] DevAccessCount, StallCycleCount;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.DEV_BASE(32'h0000_7F00), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
        .AddrM(AddrM), .WriteDataM(WriteDataM), .InterruptRequest(InterruptRequest),
        .DMRData(DMRData), .DMWE(DMWE), .DMBE(DMBE), .DMWData(DMWData),
        .DevReq(DevReq), .DevWE(DevWE), .DevAddr(DevAddr), .DevBE(DevBE),
        .DevWData(DevWData), .DevAck(DevAck), .DevRData(DevRData),
        .CPURD(CPURD), .ReadDataHM(ReadDataHM), .ReadDataBM(ReadDataBM),
        .StallM(StallM), .AdELM(AdELM), .AdESM(AdESM),
`ifdef MEM_ACCESS_STATS_EN
        .DevAccessCount(DevAccessCount), .StallCycleCount(StallCycleCount),
`endif
        .BusErrM(BusErrM)
    );

    typedef struct {
        logic [31:0] cpurd;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t        sb_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          n_starts = 0;
    int          n_stall_cyc = 0;
    logic [31:0] last_cpurd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd, input logic irq);
        @(negedge clk);
        MemReadM = rd; MemWriteM = wr; MemSizeM = size;
        AddrM = addr; WriteDataM = wd; InterruptRequest = irq; DevAck = 1'b0;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0);
    endtask

    // One device access; ack_after < 0 means the device never acknowledges.
    task automatic dev_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wd, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input int ack_after,
                              input logic [31:0] rd, input logic irq_wait);
        exp_t e;
        int   cyc;
        int   stalls;
        logic tmo;
        tmo      = (ack_after < 0) || (ack_after > int'(TIMEOUT) - 1);
        e.err    = tmo;
        e.cpurd  = tmo ? 32'h0 : (we ? last_cpurd : rd);
        e.stalls = tmo ? int'(TIMEOUT) + 1 : ack_after + 2;
        last_cpurd = e.cpurd;
        sb_q.push_back(e);
        n_starts++;
        drive(!we, we, size, addr, wd, 1'b0);
        cyc = 0;
        stalls = 0;
        while (StallM === 1'b1 && cyc < 64) begin
            stalls++;
            @(negedge clk);
            cyc++;
            DevAck = (ack_after >= 0) && (cyc == ack_after + 1);
            DevRData = DevAck ? rd : 32'hBAD0_BAD0;
            InterruptRequest = irq_wait;
            #1;
            if (cyc == 1) begin
                check("req_in_wait", DevReq, 1'b1);
                check("dev_addr", DevAddr, addr);
                check("dev_we", DevWE, we);
                check("dev_be", DevBE, exp_be);
                if (we) check("dev_wdata", DevWData, exp_wd);
            end
        end
        n_stall_cyc += stalls;
        check("done_reached", (cyc < 64), 1'b1);
        e = sb_q.pop_front();
        check("stall_cycles", stalls, e.stalls);
        check("cpurd_done", CPURD, e.cpurd);
        check("buserr_done", BusErrM, e.err);
        check("req_done", DevReq, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        MemReadM = 0; MemWriteM = 0; MemSizeM = 2'd2; AddrM = 0; WriteDataM = 0;
        InterruptRequest = 0; DMRData = 0; DevAck = 0; DevRData = 0;

        @(negedge clk); #1;
        check("rst_devreq", DevReq, 1'b0);
        check("rst_cpurd", CPURD, 32'h0);
        check("rst_stall", StallM, 1'b0);
        check("rst_devaddr", DevAddr, 32'h0);
        check("rst_devbe", DevBE, 4'h0);
        check("rst_buserr", BusErrM, 1'b0);
        check("rst_dmwe", DMWE, 1'b0);
        reset = 1'b0;

        // Internal stores: byte, half, word, top of internal range
        drive(1'b0, 1'b1, 2'd0, 32'h0000_0012, 32'h0000_00A5, 1'b0);
        check("sb_dmwe", DMWE, 1'b1);
        check("sb_dmbe", DMBE, 4'b0100);
        check("sb_wdata", DMWData, 32'hA5A5_A5A5);
        check("sb_stall", StallM, 1'b0);
        drive(1'b0, 1'b1, 2'd1, 32'h0000_0016, 32'h0000_1234, 1'b0);
        check("sh_dmbe", DMBE, 4'b1100);
        check("sh_wdata", DMWData, 32'h1234_1234);
        check("sh_devreq", DevReq, 1'b0);
        drive(1'b0, 1'b1, 2'd2, 32'h0000_0020, 32'hCAFE_F00D, 1'b0);
        check("sw_dmbe", DMBE, 4'b1111);
        check("sw_wdata", DMWData, 32'hCAFE_F00D);
        drive(1'b0, 1'b1, 2'd3, 32'h0000_7EFC, 32'h1111_2222, 1'b0);
        check("rsvd_dmwe", DMWE, 1'b1);
        check("rsvd_dmbe", DMBE, 4'b1111);
        check("rsvd_stall", StallM, 1'b0);
        drive(1'b0, 1'b1, 2'd2, 32'h0000_0020, 32'h0, 1'b1);
        check("irq_dmwe", DMWE, 1'b0);

        // Read lanes
        DMRData = 32'h1122_3344;
        drive(1'b1, 1'b0, 2'd0, 32'h0000_0041, 32'h0, 1'b0);
        check("lb1", ReadDataBM, 8'h33);
        drive(1'b1, 1'b0, 2'd0, 32'h0000_0043, 32'h0, 1'b0);
        check("lb3", ReadDataBM, 8'h11);
        drive(1'b1, 1'b0, 2'd1, 32'h0000_0042, 32'h0, 1'b0);
        check("lh2", ReadDataHM, 16'h1122);
        drive(1'b1, 1'b0, 2'd1, 32'h0000_0040, 32'h0, 1'b0);
        check("lh0", ReadDataHM, 16'h3344);

        // Misaligned accesses
        drive(1'b1, 1'b0, 2'd1, 32'h0000_0003, 32'h0, 1'b0);
        check("mis_adel", AdELM, 1'b1);
        check("mis_dmwe", DMWE, 1'b0);
        drive(1'b0, 1'b1, 2'd2, 32'h0000_0002, 32'h0, 1'b0);
        check("mis_ades", AdESM, 1'b1);
        check("mis_ades_dmwe", DMWE, 1'b0);
        check("mis_devreq", DevReq, 1'b0);
        drive(1'b1, 1'b0, 2'd2, 32'h0000_7F05, 32'h0, 1'b0);
        check("mis_dev_stall", StallM, 1'b0);
        drive(1'b1, 1'b0, 2'd2, 32'h0000_7F05, 32'h0, 1'b0);
        check("mis_dev_req", DevReq, 1'b0);
        idle();

        // Device load, ack after 3 WAIT cycles
        dev_access(1'b0, 32'h0000_7F04, 2'd2, 32'h0, 4'hF, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        idle();
        // Device store that never gets acked
        dev_access(1'b1, 32'h0000_7F08, 2'd2, 32'h0BAD_F00D, 4'hF, 32'h0BAD_F00D, -1, 32'h0, 1'b0);
        idle();
        check("buserr_one_cycle", BusErrM, 1'b0);
        // Ack on the timeout cycle, then a back-to-back store with IRQ in WAIT
        dev_access(1'b0, 32'h0000_7F00, 2'd2, 32'h0, 4'hF, 32'h0, int'(TIMEOUT) - 1, 32'h1234_5678, 1'b0);
        dev_access(1'b1, 32'h0000_7F0A, 2'd1, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 0, 32'h0, 1'b1);
        idle();
        check("cpurd_hold", CPURD, 32'h1234_5678);

        // Interrupt pending in IDLE blocks the device access
        drive(1'b1, 1'b0, 2'd2, 32'h0000_7F20, 32'h0, 1'b1);
        check("irq_idle_stall", StallM, 1'b0);
        drive(1'b1, 1'b0, 2'd2, 32'h0000_7F20, 32'h0, 1'b1);
        check("irq_idle_req", DevReq, 1'b0);
        idle();

`ifdef MEM_ACCESS_STATS_EN
        check("stat_dev", DevAccessCount, 32'(n_starts));
        check("stat_stall", StallCycleCount, 32'(n_stall_cyc));
`endif

        // Asynchronous reset in the middle of WAIT
        drive(1'b1, 1'b0, 2'd2, 32'h0000_7F24, 32'h0, 1'b0);
        check("pre_rst_stall", StallM, 1'b1);
        drive(1'b1, 1'b0, 2'd2, 32'h0000_7F24, 32'h0, 1'b0);
        check("pre_rst_req", DevReq, 1'b1);
        MemReadM = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_req", DevReq, 1'b0);
        check("arst_stall", StallM, 1'b0);
        check("arst_cpurd", CPURD, 32'h0);
        check("arst_devaddr", DevAddr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        DevAck = 1'b1;
        DevRData = 32'hFFFF_FFFF;
        @(negedge clk);
        DevAck = 1'b0;
        #1;
        check("late_ack_cpurd", CPURD, 32'h0);
        check("late_ack_req", DevReq, 1'b0);
        check("late_ack_stall", StallM, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
